layer_seq_ctrl: RTL and testbench

Sequencer for a single-MAC fully-connected layer datapath computing y = ReLU(W·x + b), with W (M×N) and b (M) held in ROMs. It accepts N input words over a valid/ready stream and writes them into the x memory. For each of the M rows it then issues bias/weight/x read addresses and drives accumulator-control strobes aligned to the memory read latency. It owns the output valid/ready handshake and stalls only at row boundaries when the output register is still occupied.

---
 rtl/layer_seq_pkg.sv | 22 ++
 rtl/rd_lat_pipe.sv | 29 ++
 rtl/layer_seq_ctrl.sv | 149 ++++++++++++++
 tb/tb_layer_seq_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/layer_seq_pkg.sv
// Shared types and width helpers for the fully-connected layer sequencer.
package layer_seq_pkg;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_CAPTURE
  } state_t;

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_BIAS,
    TAG_MAC
  } tag_t;

  // Address widths never collapse to zero bits, even for a depth of one.
  function automatic int max1clog2(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/rd_lat_pipe.sv
// Delays issue-slot tags by the memory read latency so the accumulator strobes
// line up with the data returning from the x memory and the ROMs.
module rd_lat_pipe
  import layer_seq_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  tag_t i_tag,
  output logic o_acc_load_bias,
  output logic o_acc_en
);

  tag_t r_tag_p [RD_LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) r_tag_p[i] <= TAG_NONE;
    end else begin
      r_tag_p[0] <= i_tag;
      for (int i = 1; i < RD_LAT; i++) r_tag_p[i] <= r_tag_p[i-1];
    end
  end

  assign o_acc_load_bias = (r_tag_p[RD_LAT-1] == TAG_BIAS);
  assign o_acc_en        = (r_tag_p[RD_LAT-1] == TAG_MAC);

endmodule

// File: rtl/layer_seq_ctrl.sv
// Sequencer for a single-MAC y = ReLU(W*x + b) layer: loads x, then walks the
// M rows issuing bias/weight/x reads and latency-aligned accumulator strobes.
module layer_seq_ctrl
  import layer_seq_pkg::*;
#(
  parameter int M      = 8,
  parameter int N      = 4,
  parameter int RD_LAT = 1,
  parameter int LOGN   = max1clog2(N),
  parameter int LOGM   = max1clog2(M),
  parameter int LOGW   = max1clog2(M*N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_valid,
  output logic            s_ready,
  output logic            x_wr_en,
  output logic [LOGN-1:0] x_addr,
  output logic [LOGW-1:0] w_addr,
  output logic [LOGM-1:0] b_addr,
  output logic            acc_load_bias,
  output logic            acc_en,
  output logic            y_capture,
  output logic            m_valid,
  input  logic            m_ready
);

  // Slot counter must reach N (bias slot plus N mac slots) and RD_LAT-1.
  localparam int KW = LOGN + 1;
  localparam logic [KW-1:0]   K_LAST    = KW'(N);
  localparam logic [KW-1:0]   K_ONE     = KW'(1);
  localparam logic [KW-1:0]   WAIT_LAST = KW'(RD_LAT - 1);
  localparam logic [LOGN-1:0] J_LAST    = LOGN'(N - 1);
  localparam logic [LOGN-1:0] J_ONE     = LOGN'(1);
  localparam logic [LOGM-1:0] ROW_LAST  = LOGM'(M - 1);
  localparam logic [LOGM-1:0] ROW_ONE   = LOGM'(1);
  localparam logic [LOGW-1:0] W_STEP    = LOGW'(N);

  state_t          r_state;
  logic [LOGN-1:0] r_j;
  logic [KW-1:0]   r_k;
  logic [LOGM-1:0] r_row;
  logic [LOGW-1:0] r_wbase;
  logic [LOGW-1:0] r_w_addr;
  logic [LOGN-1:0] r_x_addr;
  logic            r_m_valid;

  logic            w_accept;
  logic            w_fire;
  logic            w_pipe_load_bias;
  logic            w_pipe_acc_en;
  tag_t            w_tag;

  assign s_ready   = (r_state == ST_LOAD) && !reset;
  assign w_accept  = s_valid && s_ready;
  assign x_wr_en   = w_accept;
  assign w_fire    = (r_state == ST_CAPTURE) && (!r_m_valid || m_ready) && !reset;
  assign y_capture = w_fire;
  assign m_valid   = r_m_valid;
  assign x_addr    = r_x_addr;
  assign w_addr    = r_w_addr;
  assign b_addr    = r_row;

  always_comb begin
    w_tag = TAG_NONE;
    if (r_state == ST_ISSUE) w_tag = (r_k == '0) ? TAG_BIAS : TAG_MAC;
  end

  rd_lat_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_lat_pipe (
    .clk             (clk),
    .reset           (reset),
    .i_tag           (w_tag),
    .o_acc_load_bias (w_pipe_load_bias),
    .o_acc_en        (w_pipe_acc_en)
  );

  assign acc_load_bias = w_pipe_load_bias && !reset;
  assign acc_en        = w_pipe_acc_en && !reset;

  // Addresses are loaded one cycle ahead so each slot sees its own address.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_LOAD;
      r_j       <= '0;
      r_k       <= '0;
      r_row     <= '0;
      r_wbase   <= '0;
      r_w_addr  <= '0;
      r_x_addr  <= '0;
      r_m_valid <= 1'b0;
    end else begin
      if (w_fire)       r_m_valid <= 1'b1;
      else if (m_ready) r_m_valid <= 1'b0;

      case (r_state)
        ST_LOAD: begin
          if (w_accept) begin
            if (r_j == J_LAST) begin
              r_j      <= '0;
              r_k      <= '0;
              r_row    <= '0;
              r_wbase  <= '0;
              r_x_addr <= '0;
              r_state  <= ST_ISSUE;
            end else begin
              r_j      <= r_j + J_ONE;
              r_x_addr <= r_j + J_ONE;
            end
          end
        end
        ST_ISSUE: begin
          if (r_k == K_LAST) begin
            r_k     <= '0;
            r_state <= ST_WAIT;
          end else begin
            r_x_addr <= r_k[LOGN-1:0];
            r_w_addr <= r_wbase + LOGW'(r_k);
            r_k      <= r_k + K_ONE;
          end
        end
        ST_WAIT: begin
          if (r_k == WAIT_LAST) begin
            r_k     <= '0;
            r_state <= ST_CAPTURE;
          end else begin
            r_k <= r_k + K_ONE;
          end
        end
        ST_CAPTURE: begin
          if (w_fire) begin
            if (r_row == ROW_LAST) begin
              r_x_addr <= '0;
              r_state  <= ST_LOAD;
            end else begin
              r_row   <= r_row + ROW_ONE;
              r_wbase <= r_wbase + W_STEP;
              r_k     <= '0;
              r_state <= ST_ISSUE;
            end
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Directed bench for layer_seq_ctrl (M=8, N=4) with RD_LAT=1 and RD_LAT=3 instances.
module tb_layer_seq_ctrl;

  logic clk = 1'b0;
  logic reset, s_valid, m_ready;

  logic       s_ready, x_wr_en, acc_load_bias, acc_en, y_capture, m_valid;
  logic [1:0] x_addr;
  logic [4:0] w_addr;
  logic [2:0] b_addr;

  logic       s_ready3, x_wr_en3, acc_load_bias3, acc_en3, y_capture3, m_valid3;
  logic [1:0] x_addr3;
  logic [4:0] w_addr3;
  logic [2:0] b_addr3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  layer_seq_ctrl #(.M(8), .N(4), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .x_wr_en(x_wr_en), .x_addr(x_addr), .w_addr(w_addr), .b_addr(b_addr),
    .acc_load_bias(acc_load_bias), .acc_en(acc_en), .y_capture(y_capture),
    .m_valid(m_valid), .m_ready(m_ready)
  );

  layer_seq_ctrl #(.M(8), .N(4), .RD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready3),
    .x_wr_en(x_wr_en3), .x_addr(x_addr3), .w_addr(w_addr3), .b_addr(b_addr3),
    .acc_load_bias(acc_load_bias3), .acc_en(acc_en3), .y_capture(y_capture3),
    .m_valid(m_valid3), .m_ready(m_ready)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
  endtask

  // Cycle 0 is the first cycle after the current one; the DUT must be in LOAD with j=0.
  task automatic run_full();
    int nhs, ny, ny3, bad;
    nhs = 0; ny = 0; ny3 = 0; bad = 0;
    for (int c = 0; c <= 61; c++) begin
      @(posedge clk); #1;
      s_valid = (c < 4);
      m_ready = 1'b1;
      @(negedge clk);
      if (s_valid && s_ready) begin
        chk("load_x_addr", x_addr, nhs);
        chk("load_x_wr_en", x_wr_en, 1);
        nhs++;
      end
      if (c == 4) begin
        chk("issue_s_ready", s_ready, 0);
        chk("issue_b_addr0", b_addr, 0);
      end
      if (c >= 5 && c <= 8) chk("row0_w_addr", w_addr, c - 5);
      if (c == 5) chk("row0_load_bias", acc_load_bias, 1);
      if (c >= 6 && c <= 9) chk("row0_acc_en", acc_en, 1);
      if (c == 10) begin
        chk("row0_acc_en_off", acc_en, 0);
        chk("row0_y_capture", y_capture, 1);
      end
      if (c == 11) chk("row1_b_addr", b_addr, 1);
      if (y_capture) begin
        chk("ycap_cycle", c, 10 + 7 * ny);
        ny++;
      end
      if (y_capture3) begin
        chk("ycap3_cycle", c, 12 + 9 * ny3);
        ny3++;
      end
      if ((acc_load_bias && acc_en) || (y_capture && acc_en) ||
          (acc_load_bias3 && acc_en3) || (y_capture3 && acc_en3)) bad++;
      if (c == 60) begin
        chk("end_s_ready", s_ready, 1);
        chk("end_m_valid", m_valid, 1);
        chk("end_w_addr", w_addr, 31);
        chk("end_b_addr", b_addr, 7);
      end
      if (c == 61) chk("end_m_valid_drained", m_valid, 0);
    end
    chk("handshakes", nhs, 4);
    chk("ycap_count", ny, 8);
    chk("ycap3_count", ny3, 6);
    chk("strobe_overlap", bad, 0);
  endtask

  initial begin
    int nhs, bad;
    logic [6:0] pat;
    reset = 1'b1; s_valid = 1'b0; m_ready = 1'b1;

    do_reset();
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_x_wr_en", x_wr_en, 0);
    chk("rst_load_bias", acc_load_bias, 0);
    chk("rst_acc_en", acc_en, 0);
    chk("rst_y_capture", y_capture, 0);
    chk("rst_x_addr", x_addr, 0);
    chk("rst_w_addr", w_addr, 0);
    chk("rst_b_addr", b_addr, 0);

    run_full();

    // Output back-pressure: row 1 stalls until m_ready rises at cycle 20.
    do_reset();
    for (int c = 0; c <= 22; c++) begin
      @(posedge clk); #1;
      s_valid = (c < 4);
      m_ready = (c == 20);
      @(negedge clk);
      if (c == 10) chk("bp_row0_ycap", y_capture, 1);
      if (c == 11) chk("bp_m_valid_set", m_valid, 1);
      if (c == 17) chk("bp_stall_ycap", y_capture, 0);
      if (c == 19) begin
        chk("bp_stall_ycap_hold", y_capture, 0);
        chk("bp_stall_b_addr", b_addr, 1);
        chk("bp_stall_w_addr", w_addr, 7);
        chk("bp_stall_m_valid", m_valid, 1);
      end
      if (c == 20) chk("bp_release_ycap", y_capture, 1);
      if (c == 21) begin
        chk("bp_m_valid_kept", m_valid, 1);
        chk("bp_row2_b_addr", b_addr, 2);
      end
      if (c == 22) chk("bp_m_valid_no_ready", m_valid, 1);
    end

    // Gapped input stream: words accepted at cycles 0, 3, 4 and 6.
    do_reset();
    pat = 7'b1011001;
    nhs = 0;
    for (int c = 0; c <= 7; c++) begin
      @(posedge clk); #1;
      s_valid = (c < 7) ? pat[c] : 1'b0;
      m_ready = 1'b1;
      @(negedge clk);
      if (c < 7) begin
        chk("gap_x_wr_en", x_wr_en, pat[c]);
        chk("gap_x_addr", x_addr, nhs);
        if (x_wr_en) nhs++;
      end
      if (c == 7) begin
        chk("gap_issue_s_ready", s_ready, 0);
        chk("gap_issue_b_addr", b_addr, 0);
      end
    end
    chk("gap_handshakes", nhs, 4);

    // Reset while row 3 is mid-issue, then a clean full run.
    do_reset();
    bad = 0;
    for (int c = 0; c <= 38; c++) begin
      @(posedge clk); #1;
      s_valid = (c < 4);
      m_ready = 1'b1;
      reset   = (c == 27);
      @(negedge clk);
      if (c == 25) chk("mid_row3_b_addr", b_addr, 3);
      if (c == 28) begin
        chk("mid_rst_s_ready", s_ready, 1);
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_acc_en", acc_en, 0);
        chk("mid_rst_y_capture", y_capture, 0);
        chk("mid_rst_b_addr", b_addr, 0);
        chk("mid_rst_w_addr", w_addr, 0);
      end
      if (c >= 28 && (acc_en || acc_load_bias || y_capture || acc_en3 || y_capture3)) bad++;
    end
    chk("mid_rst_quiet", bad, 0);
    s_valid = 1'b0;

    run_full();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
